// File: rtl/pcie_cpl_hdr_gen.sv
// Completion header generator: turns a 4DW memory read request into 3DW CplD
// headers split on MPS/RCB boundaries, or a single UR completion for anything else.
module pcie_cpl_hdr_gen #(
    parameter int MAX_PAYLOAD_SIZE         = 128,
    parameter int READ_COMPLETION_BOUNDARY = 64,
    parameter int MAX_READ_REQ_SIZE        = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] req_hdr_i,
    input  logic [15:0]  completer_id_i,
    output logic         cpl_valid_o,
    input  logic         cpl_ready_i,
    output logic [95:0]  cpl_hdr_o,
    output logic         cpl_last_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    // RCB is a power of two, so flooring to it is a mask
    localparam logic [63:0] MPS      = 64'(MAX_PAYLOAD_SIZE);
    localparam logic [63:0] RCB_MASK = ~(64'(READ_COMPLETION_BOUNDARY) - 64'd1);
    localparam logic [13:0] MRRS     = 14'(MAX_READ_REQ_SIZE);

    function automatic logic [1:0] leadZeros(input logic [3:0] be);
        casez (be)
            4'b???1: leadZeros = 2'd0;
            4'b??10: leadZeros = 2'd1;
            4'b?100: leadZeros = 2'd2;
            4'b1000: leadZeros = 2'd3;
            default: leadZeros = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tailZeros(input logic [3:0] be);
        casez (be)
            4'b1???: tailZeros = 2'd0;
            4'b01??: tailZeros = 2'd1;
            4'b001?: tailZeros = 2'd2;
            default: tailZeros = 2'd3;
        endcase
    endfunction

    logic [1:0]  r_state;
    logic [2:0]  r_tc;
    logic        r_attrH;
    logic [1:0]  r_attrL;
    logic [15:0] r_reqId;
    logic [7:0]  r_tag;
    logic [15:0] r_cplId;
    logic [3:0]  r_firstBe;
    logic [3:0]  r_lastBe;
    logic        r_lenOne;
    logic        r_isUr;
    logic        r_first;
    logic [63:0] r_curAddr;
    logic [10:0] r_remDw;
    logic        r_cplValid;
    logic        r_cplLast;
    logic [95:0] r_cplHdr;

    logic [9:0]  w_reqLen10;
    logic [10:0] w_reqLenDw;
    logic        w_reqIsMrd;
    logic        w_reqTooBig;
    logic [63:0] w_reqAddr;
    logic [1:0]  w_lz;
    logic [1:0]  w_tz;
    logic [63:0] w_boundary;
    logic [63:0] w_maxBytes;
    logic [63:0] w_remBytes;
    logic [63:0] w_chunkBytes;
    logic [10:0] w_chunkDw;
    logic [12:0] w_byteCount;
    logic [6:0]  w_lowerAddr;
    logic        w_last;
    logic [95:0] w_cplHdr;
    logic        w_unused;

    assign w_reqLen10  = {req_hdr_i[17:16], req_hdr_i[31:24]};
    assign w_reqLenDw  = (w_reqLen10 == 10'd0) ? 11'd1024 : {1'b0, w_reqLen10};
    assign w_reqIsMrd  = (req_hdr_i[7:5] == 3'b001) && (req_hdr_i[4:0] == 5'b00000);
    assign w_reqTooBig = {1'b0, w_reqLenDw, 2'b00} > MRRS;
    assign w_reqAddr   = {req_hdr_i[95:64], req_hdr_i[119:96], req_hdr_i[127:122], 2'b00};

    // A single-DW read takes both byte-enable edges from the first BE
    assign w_lz = leadZeros(r_firstBe);
    assign w_tz = r_lenOne ? tailZeros(r_firstBe) : tailZeros(r_lastBe);

    assign w_boundary   = (r_curAddr + MPS) & RCB_MASK;
    assign w_maxBytes   = w_boundary - r_curAddr;
    assign w_remBytes   = {51'd0, r_remDw, 2'b00};
    assign w_chunkBytes = (w_remBytes < w_maxBytes) ? w_remBytes : w_maxBytes;
    assign w_chunkDw    = w_chunkBytes[12:2];
    assign w_byteCount  = {r_remDw, 2'b00} - (r_first ? {11'd0, w_lz} : 13'd0) - {11'd0, w_tz};
    assign w_lowerAddr  = r_first ? {r_curAddr[6:2], w_lz} : r_curAddr[6:0];
    assign w_last       = r_isUr || (w_chunkDw == r_remDw);

    assign w_unused = &{req_hdr_i[23:22], req_hdr_i[19:18], req_hdr_i[15], req_hdr_i[11],
                        req_hdr_i[9:8], req_hdr_i[121:120], w_byteCount[12]};

    always_comb begin
        w_cplHdr         = '0;
        w_cplHdr[4:0]    = 5'b01010;
        w_cplHdr[10]     = r_attrH;
        w_cplHdr[14:12]  = r_tc;
        w_cplHdr[21:20]  = r_attrL;
        w_cplHdr[47:32]  = r_cplId;
        w_cplHdr[79:64]  = r_reqId;
        w_cplHdr[87:80]  = r_tag;
        if (r_isUr) begin
            w_cplHdr[7:5]   = 3'b000;
            w_cplHdr[55:53] = 3'b001;
        end else begin
            w_cplHdr[7:5]   = 3'b010;
            w_cplHdr[17:16] = w_chunkDw[9:8];
            w_cplHdr[31:24] = w_chunkDw[7:0];
            w_cplHdr[51:48] = w_byteCount[11:8];
            w_cplHdr[63:56] = w_byteCount[7:0];
            w_cplHdr[94:88] = w_lowerAddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tc       <= '0;
            r_attrH    <= 1'b0;
            r_attrL    <= '0;
            r_reqId    <= '0;
            r_tag      <= '0;
            r_cplId    <= '0;
            r_firstBe  <= '0;
            r_lastBe   <= '0;
            r_lenOne   <= 1'b0;
            r_isUr     <= 1'b0;
            r_first    <= 1'b0;
            r_curAddr  <= '0;
            r_remDw    <= '0;
            r_cplValid <= 1'b0;
            r_cplLast  <= 1'b0;
            r_cplHdr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_tc      <= req_hdr_i[14:12];
                        r_attrH   <= req_hdr_i[10];
                        r_attrL   <= req_hdr_i[21:20];
                        r_reqId   <= req_hdr_i[47:32];
                        r_tag     <= req_hdr_i[55:48];
                        r_firstBe <= req_hdr_i[59:56];
                        r_lastBe  <= req_hdr_i[63:60];
                        r_cplId   <= completer_id_i;
                        r_lenOne  <= (w_reqLenDw == 11'd1);
                        r_isUr    <= !w_reqIsMrd || w_reqTooBig;
                        r_first   <= 1'b1;
                        r_curAddr <= w_reqAddr;
                        r_remDw   <= w_reqLenDw;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_cplHdr   <= w_cplHdr;
                    r_cplLast  <= w_last;
                    r_cplValid <= 1'b1;
                    r_curAddr  <= r_curAddr + w_chunkBytes;
                    r_remDw    <= r_remDw - w_chunkDw;
                    r_first    <= 1'b0;
                    r_state    <= S_EMIT;
                end
                S_EMIT: begin
                    if (cpl_ready_i) begin
                        if (r_cplLast) begin
                            r_cplValid <= 1'b0;
                            r_cplLast  <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cplHdr  <= w_cplHdr;
                            r_cplLast <= w_last;
                            r_curAddr <= r_curAddr + w_chunkBytes;
                            r_remDw   <= r_remDw - w_chunkDw;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = rst_n && (r_state == S_IDLE);
    assign cpl_valid_o = r_cplValid;
    assign cpl_hdr_o   = r_cplHdr;
    assign cpl_last_o  = r_cplLast;

endmodule

// File: tb/tb_pcie_cpl_hdr_gen.sv
// Directed bench for pcie_cpl_hdr_gen: hand-computed completion headers for
// single/multi-chunk reads, partial byte enables, UR cases, backpressure and reset.
module tb_pcie_cpl_hdr_gen;
    localparam logic [15:0] CPL_ID = 16'hBEEF;
    localparam logic [15:0] REQ_ID = 16'h1234;
    localparam logic [7:0]  TAG    = 8'h5A;
    localparam logic [2:0]  TC     = 3'd5;
    localparam logic        ATTR_H = 1'b1;
    localparam logic [1:0]  ATTR_L = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [127:0] req_hdr_i;
    logic [15:0]  completer_id_i;
    logic         cpl_valid_o;
    logic         cpl_ready_i;
    logic [95:0]  cpl_hdr_o;
    logic         cpl_last_o;

    int nAsserts = 0;
    int nFails   = 0;

    pcie_cpl_hdr_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_hdr_i      (req_hdr_i),
        .completer_id_i (completer_id_i),
        .cpl_valid_o    (cpl_valid_o),
        .cpl_ready_i    (cpl_ready_i),
        .cpl_hdr_o      (cpl_hdr_o),
        .cpl_last_o     (cpl_last_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    function automatic logic [127:0] mkReq(input logic [2:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len, input logic [63:0] addr,
                                           input logic [3:0] fbe, input logic [3:0] lbe);
        logic [127:0] h;
        h          = '0;
        h[7:5]     = fmt;
        h[4:0]     = typ;
        h[8]       = 1'b1;
        h[10]      = ATTR_H;
        h[14:12]   = TC;
        h[17:16]   = len[9:8];
        h[21:20]   = ATTR_L;
        h[31:24]   = len[7:0];
        h[47:32]   = REQ_ID;
        h[55:48]   = TAG;
        h[59:56]   = fbe;
        h[63:60]   = lbe;
        h[95:64]   = addr[63:32];
        h[119:96]  = addr[31:8];
        h[127:122] = addr[7:2];
        return h;
    endfunction

    function automatic logic [95:0] mkCpl(input logic [2:0] fmt, input logic [2:0] st,
                                          input logic [9:0] len, input logic [11:0] bc,
                                          input logic [6:0] la);
        logic [95:0] h;
        h         = '0;
        h[7:5]    = fmt;
        h[4:0]    = 5'b01010;
        h[10]     = ATTR_H;
        h[14:12]  = TC;
        h[17:16]  = len[9:8];
        h[21:20]  = ATTR_L;
        h[31:24]  = len[7:0];
        h[47:32]  = CPL_ID;
        h[51:48]  = bc[11:8];
        h[55:53]  = st;
        h[63:56]  = bc[7:0];
        h[79:64]  = REQ_ID;
        h[87:80]  = TAG;
        h[94:88]  = la;
        return h;
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nAsserts++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request; returns at the negedge where the first completion should be visible
    task automatic applyStimulus(input string tag, input logic [127:0] hdr);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 96'(req_ready_o), 96'd1);
        req_valid_i = 1'b1;
        req_hdr_i   = hdr;
        @(negedge clk);
        req_valid_i = 1'b0;
        req_hdr_i   = '0;
        checkOutput({tag, "_decodeValid"}, 96'(cpl_valid_o), 96'd0);
        checkOutput({tag, "_decodeReady"}, 96'(req_ready_o), 96'd0);
        @(negedge clk);
    endtask

    task automatic expectCpl(input string tag, input logic [95:0] hdr, input logic last);
        checkOutput({tag, "_valid"}, 96'(cpl_valid_o), 96'd1);
        checkOutput({tag, "_hdr"}, cpl_hdr_o, hdr);
        checkOutput({tag, "_last"}, 96'(cpl_last_o), 96'(last));
        @(negedge clk);
    endtask

    task automatic expectIdle(input string tag);
        checkOutput({tag, "_idleValid"}, 96'(cpl_valid_o), 96'd0);
        checkOutput({tag, "_idleReady"}, 96'(req_ready_o), 96'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid_i    = 1'b0;
        req_hdr_i      = '0;
        completer_id_i = CPL_ID;
        cpl_ready_i    = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 96'(cpl_valid_o), 96'd0);
        checkOutput("rst_last", 96'(cpl_last_o), 96'd0);
        checkOutput("rst_hdr", cpl_hdr_o, 96'd0);
        checkOutput("rst_ready", 96'(req_ready_o), 96'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready", 96'(req_ready_o), 96'd1);

        applyStimulus("single", mkReq(3'b001, 5'b0, 10'd32, 64'h1000, 4'hF, 4'hF));
        expectCpl("single", mkCpl(3'b010, 3'b000, 10'd32, 12'd128, 7'h00), 1'b1);
        expectIdle("single");

        applyStimulus("split", mkReq(3'b001, 5'b0, 10'd64, 64'h1020, 4'hF, 4'hF));
        expectCpl("split0", mkCpl(3'b010, 3'b000, 10'd24, 12'd256, 7'h20), 1'b0);
        expectCpl("split1", mkCpl(3'b010, 3'b000, 10'd32, 12'd160, 7'h00), 1'b0);
        expectCpl("split2", mkCpl(3'b010, 3'b000, 10'd8, 12'd32, 7'h00), 1'b1);
        expectIdle("split");

        applyStimulus("oneDw", mkReq(3'b001, 5'b0, 10'd1, 64'h2004, 4'b0100, 4'b0000));
        expectCpl("oneDw", mkCpl(3'b010, 3'b000, 10'd1, 12'd1, 7'h06), 1'b1);
        expectIdle("oneDw");

        applyStimulus("oneDwNoBe", mkReq(3'b001, 5'b0, 10'd1, 64'h2008, 4'b0000, 4'b0000));
        expectCpl("oneDwNoBe", mkCpl(3'b010, 3'b000, 10'd1, 12'd1, 7'h08), 1'b1);

        applyStimulus("partBe", mkReq(3'b001, 5'b0, 10'd4, 64'h0000_00AB_0000_3008, 4'b1100, 4'b0011));
        expectCpl("partBe", mkCpl(3'b010, 3'b000, 10'd4, 12'd12, 7'h0A), 1'b1);

        applyStimulus("splitBe", mkReq(3'b001, 5'b0, 10'd64, 64'h1020, 4'b1110, 4'b0111));
        expectCpl("splitBe0", mkCpl(3'b010, 3'b000, 10'd24, 12'd254, 7'h21), 1'b0);
        expectCpl("splitBe1", mkCpl(3'b010, 3'b000, 10'd32, 12'd159, 7'h00), 1'b0);
        expectCpl("splitBe2", mkCpl(3'b010, 3'b000, 10'd8, 12'd31, 7'h00), 1'b1);

        applyStimulus("maxRead", mkReq(3'b001, 5'b0, 10'd128, 64'h0, 4'hF, 4'hF));
        expectCpl("maxRead0", mkCpl(3'b010, 3'b000, 10'd32, 12'd512, 7'h00), 1'b0);
        expectCpl("maxRead1", mkCpl(3'b010, 3'b000, 10'd32, 12'd384, 7'h00), 1'b0);
        expectCpl("maxRead2", mkCpl(3'b010, 3'b000, 10'd32, 12'd256, 7'h00), 1'b0);
        expectCpl("maxRead3", mkCpl(3'b010, 3'b000, 10'd32, 12'd128, 7'h00), 1'b1);

        applyStimulus("urLen", mkReq(3'b001, 5'b0, 10'd200, 64'h4000, 4'hF, 4'hF));
        expectCpl("urLen", mkCpl(3'b000, 3'b001, 10'd0, 12'd0, 7'h00), 1'b1);
        expectIdle("urLen");

        applyStimulus("urLen1024", mkReq(3'b001, 5'b0, 10'd0, 64'h4000, 4'hF, 4'hF));
        expectCpl("urLen1024", mkCpl(3'b000, 3'b001, 10'd0, 12'd0, 7'h00), 1'b1);

        applyStimulus("urWrite", mkReq(3'b010, 5'b0, 10'd4, 64'h4000, 4'hF, 4'hF));
        expectCpl("urWrite", mkCpl(3'b000, 3'b001, 10'd0, 12'd0, 7'h00), 1'b1);
        expectIdle("urWrite");

        applyStimulus("stall", mkReq(3'b001, 5'b0, 10'd64, 64'h1020, 4'hF, 4'hF));
        expectCpl("stall0", mkCpl(3'b010, 3'b000, 10'd24, 12'd256, 7'h20), 1'b0);
        cpl_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stallValid", 96'(cpl_valid_o), 96'd1);
            checkOutput("stallHdr", cpl_hdr_o, mkCpl(3'b010, 3'b000, 10'd32, 12'd160, 7'h00));
            checkOutput("stallLast", 96'(cpl_last_o), 96'd0);
            checkOutput("stallReqReady", 96'(req_ready_o), 96'd0);
            @(negedge clk);
        end
        cpl_ready_i = 1'b1;
        expectCpl("stall1", mkCpl(3'b010, 3'b000, 10'd32, 12'd160, 7'h00), 1'b0);
        expectCpl("stall2", mkCpl(3'b010, 3'b000, 10'd8, 12'd32, 7'h00), 1'b1);
        expectIdle("stall");

        applyStimulus("midRst", mkReq(3'b001, 5'b0, 10'd64, 64'h1020, 4'hF, 4'hF));
        expectCpl("midRst0", mkCpl(3'b010, 3'b000, 10'd24, 12'd256, 7'h20), 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 96'(cpl_valid_o), 96'd0);
        checkOutput("midRstLast", 96'(cpl_last_o), 96'd0);
        checkOutput("midRstHdr", cpl_hdr_o, 96'd0);
        checkOutput("midRstReady", 96'(req_ready_o), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midRstRelReady", 96'(req_ready_o), 96'd1);
        checkOutput("midRstRelValid", 96'(cpl_valid_o), 96'd0);

        applyStimulus("afterRst", mkReq(3'b001, 5'b0, 10'd32, 64'h1000, 4'hF, 4'hF));
        expectCpl("afterRst", mkCpl(3'b010, 3'b000, 10'd32, 12'd128, 7'h00), 1'b1);
        expectIdle("afterRst");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/pcie_cpl_hdr_gen.md
PCIE_CPL_HDR_GEN -- requirements
Module: pcie_cpl_hdr_gen

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD_SIZE, default 128, max completion payload in bytes.
REQ-002 SHALL have parameter READ_COMPLETION_BOUNDARY, default 64, RCB in bytes.
REQ-003 SHALL have parameter MAX_READ_REQ_SIZE, default 512, largest serviceable request in bytes.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1  request header valid.
REQ-007 SHALL have port req_ready_o  output  1  request header accepted when valid&&ready.
REQ-008 SHALL have port req_hdr_i  input  128  4DW memory request header: fmt[7:5], type[4:0], th[8], attr_h[10], tc[14:12], length_h[17:16], attr_l[21:20], length_l[31:24], requester_id[47:32], tag[55:48], byte_enable[63:56] (first BE [59:56], last BE [63:60]), addr_h[95:64]=addr[63:32], addr_m[119:96]=addr[31:8], addr_l[127:122]=addr[7:2].
REQ-009 SHALL have port completer_id_i  input  16  completer ID inserted into every completion.
REQ-010 SHALL have port cpl_valid_o  output  1  completion header valid.
REQ-011 SHALL have port cpl_ready_i  input  1  downstream accepts header.
REQ-012 SHALL have port cpl_hdr_o  output  96  3DW completion header: fmt[7:5], type[4:0], attr_h[10], tc[14:12], length_h[17:16], attr_l[21:20], length_l[31:24], completer_id[47:32], byte_count_h[51:48], bcm[52], cpl_status[55:53], byte_count_l[63:56], requester_id[79:64], tag[87:80], lower_addr[94:88], bit 95 zero.
REQ-013 SHALL have port cpl_last_o  output  1  marks final completion of current request.

Function
REQ-014 SHALL implement FSM IDLE -> DECODE -> EMIT -> IDLE; req_ready_o=1 only in IDLE.
REQ-015 SHALL capture req_hdr_i and completer_id_i on handshake, go to DECODE; first cpl_valid_o asserts exactly 2 cycles after accept cycle.
REQ-016 SHALL classify as MRd only if fmt=001 and type=00000; length field 0 encodes 1024 DW.
REQ-017 SHALL issue UR if not MRd or length*4 > MAX_READ_REQ_SIZE: one header, fmt=000, type=01010, cpl_status=001, length=0, byte_count=0, lower_addr=0, cpl_last_o=1.
REQ-018 SHALL compute byte total = 4*length - lz - tz; lz from first BE (xxx1:0, xx10:1, x100:2, 1000:3); tz from last BE (1xxx:0, 01xx:1, 001x:2, 0001:3); length 1 ignores last BE; length 1 with first BE 0000 gives total 1, lz 0.
REQ-019 SHALL split MRd into CplD headers (fmt=010, type=01010, status=000): chunk from DW address A ends at min(request end, floor((A+MAX_PAYLOAD_SIZE)/RCB)*RCB); length = chunk bytes/4.
REQ-020 SHALL set byte_count = bytes remaining from current chunk start, 12-bit split h/l, first chunk reduced by lz and tz, later chunks by tz only.
REQ-021 SHALL set lower_addr = {A[6:2], lz[1:0]} on first chunk, A[6:0] on later chunks.
REQ-022 SHALL copy tag, requester_id, tc, attr_h, attr_l from request; td, ep, th, bcm, reserved bits = 0.
REQ-023 SHALL hold cpl_hdr_o and cpl_last_o stable while cpl_valid_o && !cpl_ready_i.
REQ-024 SHALL present next chunk header the cycle after each handshake (no bubble); after handshake with cpl_last_o=1, deassert cpl_valid_o and return to IDLE (req_ready_o=1 next cycle).
REQ-025 SHALL keep address arithmetic 64-bit; chunk crossing of 4 KB not split beyond REQ-019.

Reset
REQ-026 SHALL, on rst_n low (any state, including mid-EMIT), asynchronously force IDLE, cpl_valid_o=0, cpl_last_o=0, cpl_hdr_o=0, req_ready_o=0 during reset, req_ready_o=1 first cycle after release; in-flight request discarded.

Verification
REQ-027 MRd addr 0x1000, len 32, BE 0xFF -> one CplD, length 32, byte_count 128, lower_addr 0x00, last=1, valid 2 cycles after accept.
REQ-028 MRd addr 0x1020, len 64, BE 0xFF -> three CplD: (24 DW, bc 256, la 0x20), (32 DW, bc 160, la 0x00), (8 DW, bc 32, la 0x00, last), back-to-back with cpl_ready_i=1.
REQ-029 MRd addr 0x2004, len 1, first BE 0100 -> one CplD length 1, byte_count 1, lower_addr 0x06, last.
REQ-030 MRd len 200 DW, and separately fmt=010 type=00000 -> single UR header, status 001, length 0, last=1.
REQ-031 cpl_ready_i low 3 cycles during REQ-028 second header -> header bits unchanged until handshake; req_ready_o stays 0.
REQ-032 rst_n low during REQ-028 after first handshake -> cpl_valid_o=0 immediately, req_ready_o=1 first cycle after release, new request processed normally.
